// File: rtl/tangram_piece_sched.sv
// rtl/tangram_piece_sched.sv - piece select stepping, scramble sequencing and pixel ownership
module tangram_piece_sched #(
    parameter logic [19:0] DEB_CYC = 20'd400000,
    parameter logic [15:0] GAP_CYC = 16'd1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       scramble,
    input  logic       vidon,
    input  logic [6:0] pix_hit,
    output logic [6:0] sel,
    output logic [6:0] disturb,
    output logic       busy,
    output logic       pix_on,
    output logic [2:0] pix_id,
    output logic       pix_sel
);

    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] gcnt_q, gcnt_d;
    logic        scr_q;
    logic [6:0]  sel_q, sel_d;
    logic [6:0]  sel_save_q, sel_save_d;
    logic [6:0]  disturb_q, disturb_d;
    logic        busy_q, busy_d;
    logic        pix_on_q, pix_on_d;
    logic [2:0]  pix_id_q, pix_id_d;
    logic        pix_sel_q, pix_sel_d;

    logic [19:0] nxt_cnt_q, prv_cnt_q;
    logic        nxt_arm_q, prv_arm_q;
    logic        nxt_fire, prv_fire;

    // A press fires on the DEB_CYC-th consecutive high sample, once per hold.
    assign nxt_fire = btn_next && nxt_arm_q && (nxt_cnt_q == DEB_CYC - 20'd1);
    assign prv_fire = btn_prev && prv_arm_q && (prv_cnt_q == DEB_CYC - 20'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            nxt_cnt_q <= '0;
            prv_cnt_q <= '0;
            nxt_arm_q <= 1'b1;
            prv_arm_q <= 1'b1;
        end else begin
            if (btn_next) begin
                if (nxt_cnt_q != '1) nxt_cnt_q <= nxt_cnt_q + 20'd1;
                if (nxt_fire) nxt_arm_q <= 1'b0;
            end else begin
                nxt_cnt_q <= '0;
                nxt_arm_q <= 1'b1;
            end
            if (btn_prev) begin
                if (prv_cnt_q != '1) prv_cnt_q <= prv_cnt_q + 20'd1;
                if (prv_fire) prv_arm_q <= 1'b0;
            end else begin
                prv_cnt_q <= '0;
                prv_arm_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            gcnt_q     <= '0;
            scr_q      <= 1'b0;
            sel_q      <= 7'b0000001;
            sel_save_q <= 7'b0000001;
            disturb_q  <= '0;
            busy_q     <= 1'b0;
            pix_on_q   <= 1'b0;
            pix_id_q   <= '0;
            pix_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gcnt_q     <= gcnt_d;
            scr_q      <= scramble;
            sel_q      <= sel_d;
            sel_save_q <= sel_save_d;
            disturb_q  <= disturb_d;
            busy_q     <= busy_d;
            pix_on_q   <= pix_on_d;
            pix_id_q   <= pix_id_d;
            pix_sel_q  <= pix_sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (scramble && !scr_q) begin
                    state_d = ST_PULSE;
                    idx_d   = 3'd0;
                end
            end
            ST_PULSE: begin
                state_d = ST_GAP;
                gcnt_d  = '0;
            end
            ST_GAP: begin
                if (gcnt_q == GAP_CYC - 16'd1) begin
                    if (idx_q == 3'd6) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PULSE;
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    gcnt_d = gcnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they appear in the same cycle as the state.
    always_comb begin
        disturb_d  = (state_d == ST_PULSE) ? (7'b0000001 << idx_d) : 7'b0;
        busy_d     = (state_d != ST_IDLE);
        sel_save_d = sel_save_q;
        sel_d      = sel_q;
        if (state_q == ST_IDLE && state_d == ST_PULSE) begin
            sel_save_d = sel_q;
            sel_d      = 7'b0;
        end else if (state_q == ST_GAP && state_d == ST_IDLE) begin
            sel_d = sel_save_q;
        end else if (!busy_q) begin
            if (nxt_fire && !prv_fire) sel_d = {sel_q[5:0], sel_q[6]};
            else if (prv_fire && !nxt_fire) sel_d = {sel_q[0], sel_q[6:1]};
        end
    end

    logic [6:0] hit_v, own;

    // The selected piece is drawn on top; sel is blanked during a scramble so use the saved copy.
    always_comb begin
        hit_v     = vidon ? pix_hit : 7'b0;
        own       = hit_v & (busy_q ? sel_save_q : sel_q);
        pix_on_d  = |hit_v;
        pix_id_d  = 3'd0;
        pix_sel_d = 1'b0;
        if (|own) begin
            pix_sel_d = 1'b1;
            for (int i = 0; i < 7; i++) begin
                if (own[i]) pix_id_d = 3'(i);
            end
        end else begin
            for (int i = 6; i >= 0; i--) begin
                if (hit_v[i]) pix_id_d = 3'(i);
            end
        end
    end

    assign sel     = sel_q;
    assign disturb = disturb_q;
    assign busy    = busy_q;
    assign pix_on  = pix_on_q;
    assign pix_id  = pix_id_q;
    assign pix_sel = pix_sel_q;

endmodule

// File: tb/tb_tangram_piece_sched.sv
// tb/tb_tangram_piece_sched.sv - directed self-checking bench for tangram_piece_sched
module tb_tangram_piece_sched;

    logic       clk;
    logic       reset;
    logic       btn_next;
    logic       btn_prev;
    logic       scramble;
    logic       vidon;
    logic [6:0] pix_hit;
    logic [6:0] sel;
    logic [6:0] disturb;
    logic       busy;
    logic       pix_on;
    logic [2:0] pix_id;
    logic       pix_sel;

    int n_chk  = 0;
    int n_fail = 0;

    tangram_piece_sched #(
        .DEB_CYC(20'd4),
        .GAP_CYC(16'd3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .scramble(scramble),
        .vidon   (vidon),
        .pix_hit (pix_hit),
        .sel     (sel),
        .disturb (disturb),
        .busy    (busy),
        .pix_on  (pix_on),
        .pix_id  (pix_id),
        .pix_sel (pix_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic n, input logic p, input int cyc);
        btn_next = n;
        btn_prev = p;
        repeat (cyc) tick();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    logic [6:0] exp_sel;
    logic [6:0] exp_dist;

    initial begin
        reset    = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        scramble = 1'b0;
        vidon    = 1'b0;
        pix_hit  = 7'b0;
        do_reset();

        check("rst_sel", sel, 7'b0000001);
        check("rst_busy", busy, 0);
        check("rst_disturb", disturb, 0);
        check("rst_pix_on", pix_on, 0);
        check("rst_pix_id", pix_id, 0);

        exp_sel = 7'b0000001;
        for (int k = 0; k < 7; k++) begin
            press(1'b1, 1'b0, 4);
            exp_sel = {exp_sel[5:0], exp_sel[6]};
            check("next_walk", sel, exp_sel);
        end
        press(1'b1, 1'b0, 40);
        check("next_hold", sel, 7'b0000010);

        do_reset();
        press(1'b0, 1'b1, 4);
        check("prev_wrap", sel, 7'b1000000);
        press(1'b0, 1'b1, 3);
        check("prev_glitch", sel, 7'b1000000);
        press(1'b1, 1'b1, 4);
        check("both_btn", sel, 7'b1000000);

        press(1'b1, 1'b0, 4);
        press(1'b1, 1'b0, 4);
        press(1'b1, 1'b0, 4);
        check("pre_scr_sel", sel, 7'b0000100);

        // Rising edge sampled at edge s; loop index c is the cycle after edge s+c-1.
        scramble = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (c == 5) scramble = 1'b0;
            if (c == 10) scramble = 1'b1;
            exp_dist = 7'b0;
            if (c <= 25 && ((c - 1) % 4) == 0) exp_dist = 7'b0000001 << ((c - 1) / 4);
            check($sformatf("scr_disturb_c%0d", c), disturb, exp_dist);
            check($sformatf("scr_busy_c%0d", c), busy, (c <= 28) ? 1 : 0);
            check($sformatf("scr_sel_c%0d", c), sel, (c <= 28) ? 7'b0 : 7'b0000100);
        end
        scramble = 1'b0;
        tick();

        press(1'b1, 1'b0, 4);
        check("pix_pre_sel", sel, 7'b0001000);
        vidon   = 1'b1;
        pix_hit = 7'b0101001;
        tick();
        check("pix_on_a", pix_on, 1);
        check("pix_id_a", pix_id, 3);
        check("pix_sel_a", pix_sel, 1);
        pix_hit = 7'b0100010;
        tick();
        check("pix_on_b", pix_on, 1);
        check("pix_id_b", pix_id, 1);
        check("pix_sel_b", pix_sel, 0);
        vidon = 1'b0;
        tick();
        check("pix_on_c", pix_on, 0);
        check("pix_id_c", pix_id, 0);
        pix_hit = 7'b0;

        scramble = 1'b1;
        repeat (14) tick();
        check("mid_busy", busy, 1);
        check("mid_disturb", disturb, 0);
        reset = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        check("abort_disturb", disturb, 0);
        check("abort_sel", sel, 7'b0000001);
        reset    = 1'b1;
        scramble = 1'b0;
        tick();
        scramble = 1'b1;
        tick();
        check("restart_busy", busy, 1);
        check("restart_disturb", disturb, 7'b0000001);
        scramble = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
